hs_parallel_out: RTL and testbench

Output-direction parallel interface with handshake: the CPU writes bytes into it over the I/O bus, and it hands them to an external consumer (display/printer model) using the dav_/rfd protocol. It is the producer end of the same handshake that input devices drive into the input interface. A small FIFO decouples CPU writes from consumer speed. A status register (TSR) supports polling.

---
 rtl/hs_parallel_out_pkg.sv | 32 +++
 rtl/byte_fifo.sv | 58 +++++
 rtl/hs_parallel_out.sv | 144 ++++++++++++++
 tb/tb_hs_parallel_out.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_parallel_out_pkg.sv
// Shared definitions for the handshake parallel output port.
// Contents:
//   - TSR bit positions (FO, EMPTY, OVR)
//   - producer FSM state encoding
//   - a0 register-select values
//   - helper that assembles the TSR byte
package hs_parallel_out_pkg;

    localparam int TSR_FO    = 5;
    localparam int TSR_EMPTY = 4;
    localparam int TSR_OVR   = 0;

    localparam logic A0_TSR = 1'b0;
    localparam logic A0_TBR = 1'b1;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    function automatic logic [7:0] make_tsr(input logic fo, input logic empty, input logic ovr);
        logic [7:0] tsr;
        tsr            = 8'h00;
        tsr[TSR_FO]    = fo;
        tsr[TSR_EMPTY] = empty;
        tsr[TSR_OVR]   = ovr;
        return tsr;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO between CPU writes and the producer FSM.
// Ports:
//   clock, reset_ : system clock, async active-low reset
//   push, pop     : synchronous push/pop; both may occur on one edge
//   din           : byte to push
//   dout          : current head byte (combinational)
//   count         : number of stored entries, 0..DEPTH
// The caller decides push/pop acceptance.
// Pushes into a full FIFO and pops from an empty one are additionally
// dropped here, so the pointers can never corrupt.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    // Power-of-two depth: pointer overflow is the modulo-DEPTH wrap.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; an entry is only read after it was written.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/hs_parallel_out.sv
// Output parallel port with dav_/rfd handshake toward an external consumer.
// The CPU writes bytes to TBR (a0=1) and polls status in TSR (a0=0).
// Ports:
//   clock, reset_       : system clock, async active-low reset
//   s_, ior_, iow_      : chip select and I/O read/write strobes (active low)
//   a0                  : register select (0 = TSR read, 1 = TBR write)
//   d7_d0               : CPU data bus, driven only during a TSR read
//   byte_out            : byte presented to consumer
//   dav_                : data valid toward consumer (active low)
//   rfd                 : consumer ready (1) / byte taken (0)
//
// state | meaning
// S0    | idle, dav_=1, wait for a queued byte and rfd=1
// S1    | byte_out loaded, drive dav_ low on next edge
// S2    | dav_=0, wait for consumer to drop rfd, then pop
// S3    | dav_=1, wait for consumer to raise rfd again
module hs_parallel_out
    import hs_parallel_out_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic        s_,
    input  logic        ior_,
    input  logic        iow_,
    input  logic        a0,
    inout  wire  [7:0]  d7_d0,
    output logic [7:0]  byte_out,
    output logic        dav_,
    input  logic        rfd
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t      state_q;
    state_t      state_d;
    logic        dav_d;
    logic        load_byte;
    logic        pop;
    logic        push;
    logic        push_req;
    logic        tsr_rd;
    logic        tbr_wr;
    logic        tsr_rd_q;
    logic        tbr_wr_q;
    logic        ovr;
    logic        fifo_full;
    logic        empty_flag;
    logic [7:0]  fifo_dout;
    logic [AW:0] fifo_count;

    assign tsr_rd = !s_ && !ior_ && (a0 == A0_TSR);
    assign tbr_wr = !s_ && !iow_ && (a0 == A0_TBR);

    // One push per write strobe regardless of how long it is held.
    // Acceptance uses the pre-edge count, so a same-edge pop never makes room.
    assign push_req  = tbr_wr && !tbr_wr_q;
    assign fifo_full = (fifo_count == FULL_CNT);
    assign push      = push_req && !fifo_full;

    assign empty_flag = (fifo_count == '0) && (state_q == S0);
    assign d7_d0 = tsr_rd ? make_tsr(!fifo_full, empty_flag, ovr) : 8'hzz;

    byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clock  (clock),
        .reset_ (reset_),
        .push   (push),
        .pop    (pop),
        .din    (d7_d0),
        .dout   (fifo_dout),
        .count  (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            tsr_rd_q <= 1'b0;
            tbr_wr_q <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            tsr_rd_q <= tsr_rd;
            tbr_wr_q <= tbr_wr;
            // A rejected push on the same edge as a status read wins, so the
            // overrun is never silently lost.
            if (push_req && fifo_full)
                ovr <= 1'b1;
            else if (tsr_rd && !tsr_rd_q)
                ovr <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q  <= S0;
            dav_     <= 1'b1;
            byte_out <= 8'h00;
        end else begin
            state_q <= state_d;
            dav_    <= dav_d;
            if (load_byte) byte_out <= fifo_dout;
        end
    end

    always_comb begin
        state_d   = state_q;
        dav_d     = dav_;
        load_byte = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S0: begin
                dav_d = 1'b1;
                if ((fifo_count != '0) && rfd) begin
                    load_byte = 1'b1;
                    state_d   = S1;
                end
            end
            S1: begin
                dav_d   = 1'b0;
                state_d = S2;
            end
            S2: begin
                dav_d = 1'b0;
                if (!rfd) begin
                    pop     = 1'b1;
                    dav_d   = 1'b1;
                    state_d = S3;
                end
            end
            S3: begin
                dav_d = 1'b1;
                if (rfd) state_d = S0;
            end
            default: begin
                dav_d   = 1'b1;
                state_d = S0;
            end
        endcase
    end

endmodule

// File: tb/tb_hs_parallel_out.sv
module tb_hs_parallel_out;

    logic       clock = 1'b0;
    logic       reset_ = 1'b0;
    logic       s_ = 1'b1;
    logic       ior_ = 1'b1;
    logic       iow_ = 1'b1;
    logic       a0 = 1'b0;
    wire  [7:0] d7_d0;
    logic [7:0] byte_out;
    logic       dav_;
    wire        rfd;

    logic       bus_en = 1'b0;
    logic [7:0] bus_val = 8'h00;
    logic       man_rfd = 1'b1;
    logic       cons_rfd = 1'b1;
    logic       cons_auto = 1'b0;
    logic [7:0] got_q [$];
    int         max_cnt = 0;
    int         chk_cnt = 0;
    int         pass_cnt = 0;

    assign d7_d0 = bus_en ? bus_val : 8'hzz;
    assign rfd   = cons_auto ? cons_rfd : man_rfd;

    always #5 clock = ~clock;

    hs_parallel_out u_dut (
        .clock    (clock),
        .reset_   (reset_),
        .s_       (s_),
        .ior_     (ior_),
        .iow_     (iow_),
        .a0       (a0),
        .d7_d0    (d7_d0),
        .byte_out (byte_out),
        .dav_     (dav_),
        .rfd      (rfd)
    );

    // Consumer: takes the byte half a cycle after dav_ falls, re-arms half
    // a cycle after dav_ rises.
    always @(negedge clock) begin
        if (cons_auto) begin
            if (!dav_ && cons_rfd) begin
                got_q.push_back(byte_out);
                cons_rfd = 1'b0;
            end else if (dav_ && !cons_rfd) begin
                cons_rfd = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (int'(u_dut.fifo_count) > max_cnt) max_cnt = int'(u_dut.fifo_count);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cpu_write(input logic [7:0] data, input logic sel);
        @(negedge clock);
        s_ = 1'b0; iow_ = 1'b0; a0 = sel; bus_en = 1'b1; bus_val = data;
        @(negedge clock);
        s_ = 1'b1; iow_ = 1'b1; bus_en = 1'b0;
    endtask

    task automatic tsr_read(output logic [7:0] val);
        @(negedge clock);
        s_ = 1'b0; ior_ = 1'b1; a0 = 1'b0; ior_ = 1'b0;
        #1 val = d7_d0;
        @(negedge clock);
        s_ = 1'b1; ior_ = 1'b1;
    endtask

    task automatic set_auto(input logic en, input logic rfd_val);
        @(posedge clock);
        #1;
        man_rfd   = rfd_val;
        cons_auto = en;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        repeat (3) @(negedge clock);
        reset_ = 1'b1;
        #1;
        chk_cnt++;
        if (dav_ !== 1'b1) $display("FAIL reset_dav: got %b expected 1", dav_); else pass_cnt++;
        chk_cnt++;
        if (byte_out !== 8'h00) $display("FAIL reset_byte: got %h expected 00", byte_out); else pass_cnt++;
        tsr_read(v);
        chk_cnt++;
        if (v !== 8'h30) $display("FAIL reset_tsr: got %h expected 30", v); else pass_cnt++;
        // a0=0 write must be ignored
        cpu_write(8'h77, 1'b0);
        repeat (4) @(negedge clock);
        chk_cnt++;
        if (dav_ !== 1'b1) $display("FAIL ignored_write_dav: got %b expected 1", dav_); else pass_cnt++;
        tsr_read(v);
        chk_cnt++;
        if (v !== 8'h30) $display("FAIL ignored_write_tsr: got %h expected 30", v); else pass_cnt++;
    endtask

    task automatic test_latency;
        logic [7:0] v;
        got_q.delete();
        set_auto(1'b1, 1'b1);
        @(negedge clock);
        s_ = 1'b0; iow_ = 1'b0; a0 = 1'b1; bus_en = 1'b1; bus_val = 8'h41;
        @(posedge clock); #1;
        chk_cnt++;
        if (dav_ !== 1'b1) $display("FAIL lat_edge1_dav: got %b expected 1", dav_); else pass_cnt++;
        @(negedge clock);
        s_ = 1'b1; iow_ = 1'b1; bus_en = 1'b0;
        @(posedge clock); #1;
        chk_cnt++;
        if (dav_ !== 1'b1 || byte_out !== 8'h41)
            $display("FAIL lat_edge2: got dav_=%b byte=%h expected dav_=1 byte=41", dav_, byte_out);
        else pass_cnt++;
        @(posedge clock); #1;
        chk_cnt++;
        if (dav_ !== 1'b0) $display("FAIL lat_edge3_dav: got %b expected 0", dav_); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            if (dav_ && rfd) break;
            @(negedge clock);
        end
        chk_cnt++;
        if (!(dav_ === 1'b1 && rfd === 1'b1))
            $display("FAIL lat_release: got dav_=%b rfd=%b expected 1 1", dav_, rfd);
        else pass_cnt++;
        repeat (4) @(negedge clock);
        chk_cnt++;
        if (got_q.size() != 1 || got_q[0] !== 8'h41)
            $display("FAIL lat_byte: got count %0d first %h expected 1 x 41", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 8'h00);
        else pass_cnt++;
        tsr_read(v);
        chk_cnt++;
        if (v !== 8'h30) $display("FAIL lat_tsr: got %h expected 30", v); else pass_cnt++;
    endtask

    task automatic test_hold_write;
        got_q.delete();
        max_cnt = 0;
        @(negedge clock);
        s_ = 1'b0; iow_ = 1'b0; a0 = 1'b1; bus_en = 1'b1; bus_val = 8'h42;
        repeat (5) @(negedge clock);
        s_ = 1'b1; iow_ = 1'b1; bus_en = 1'b0;
        repeat (15) @(negedge clock);
        chk_cnt++;
        if (got_q.size() != 1) $display("FAIL hold_count: got %0d bytes expected 1", got_q.size()); else pass_cnt++;
        chk_cnt++;
        if (got_q.size() < 1 || got_q[0] !== 8'h42)
            $display("FAIL hold_byte: got %h expected 42", (got_q.size() > 0) ? got_q[0] : 8'h00);
        else pass_cnt++;
        chk_cnt++;
        if (max_cnt != 1) $display("FAIL hold_max_fill: got %0d expected 1", max_cnt); else pass_cnt++;
    endtask

    task automatic test_overflow;
        logic [7:0] v;
        logic [7:0] exp_b [4];
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
        set_auto(1'b0, 1'b0);
        got_q.delete();
        for (int i = 1; i <= 4; i++) cpu_write(8'(i), 1'b1);
        tsr_read(v);
        chk_cnt++;
        if (v !== 8'h00) $display("FAIL ovf_full_tsr: got %h expected 00", v); else pass_cnt++;
        cpu_write(8'h05, 1'b1);
        tsr_read(v);
        chk_cnt++;
        if (v !== 8'h01) $display("FAIL ovf_set_tsr: got %h expected 01", v); else pass_cnt++;
        tsr_read(v);
        chk_cnt++;
        if (v !== 8'h00) $display("FAIL ovf_clear_tsr: got %h expected 00", v); else pass_cnt++;
        set_auto(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) begin
            if (got_q.size() >= 4) break;
            @(negedge clock);
        end
        repeat (12) @(negedge clock);
        chk_cnt++;
        if (got_q.size() != 4) $display("FAIL ovf_delivered: got %0d bytes expected 4", got_q.size()); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (i >= got_q.size() || got_q[i] !== exp_b[i])
                $display("FAIL ovf_order[%0d]: got %h expected %h", i,
                         (i < got_q.size()) ? got_q[i] : 8'h00, exp_b[i]);
            else pass_cnt++;
        end
        tsr_read(v);
        chk_cnt++;
        if (v !== 8'h30) $display("FAIL ovf_drained_tsr: got %h expected 30", v); else pass_cnt++;
    endtask

    task automatic test_push_on_pop;
        logic [7:0] v;
        logic [7:0] exp_b [3];
        exp_b = '{8'h11, 8'h12, 8'h13};
        set_auto(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cpu_write(8'h10 + 8'(i), 1'b1);
        @(negedge clock);
        man_rfd = 1'b1;
        @(posedge clock);
        @(posedge clock); #1;
        chk_cnt++;
        if (dav_ !== 1'b0 || byte_out !== 8'h10)
            $display("FAIL pp_present: got dav_=%b byte=%h expected 0 10", dav_, byte_out);
        else pass_cnt++;
        @(negedge clock);
        man_rfd = 1'b0;
        s_ = 1'b0; iow_ = 1'b0; a0 = 1'b1; bus_en = 1'b1; bus_val = 8'h14;
        @(posedge clock); #1;
        chk_cnt++;
        if (dav_ !== 1'b1) $display("FAIL pp_pop_dav: got %b expected 1", dav_); else pass_cnt++;
        @(negedge clock);
        s_ = 1'b1; iow_ = 1'b1; bus_en = 1'b0;
        tsr_read(v);
        chk_cnt++;
        if (v !== 8'h21) $display("FAIL pp_reject_tsr: got %h expected 21", v); else pass_cnt++;
        tsr_read(v);
        chk_cnt++;
        if (v !== 8'h20) $display("FAIL pp_clear_tsr: got %h expected 20", v); else pass_cnt++;
        got_q.delete();
        set_auto(1'b1, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (got_q.size() >= 3) break;
            @(negedge clock);
        end
        repeat (12) @(negedge clock);
        chk_cnt++;
        if (got_q.size() != 3) $display("FAIL pp_delivered: got %0d bytes expected 3", got_q.size()); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            chk_cnt++;
            if (i >= got_q.size() || got_q[i] !== exp_b[i])
                $display("FAIL pp_order[%0d]: got %h expected %h", i,
                         (i < got_q.size()) ? got_q[i] : 8'h00, exp_b[i]);
            else pass_cnt++;
        end
        tsr_read(v);
        chk_cnt++;
        if (v !== 8'h30) $display("FAIL pp_final_tsr: got %h expected 30", v); else pass_cnt++;
    endtask

    task automatic test_reset_mid_handshake;
        logic [7:0] v;
        set_auto(1'b0, 1'b1);
        cpu_write(8'h55, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (!dav_) break;
            @(negedge clock);
        end
        chk_cnt++;
        if (dav_ !== 1'b0 || byte_out !== 8'h55)
            $display("FAIL rst_mid_setup: got dav_=%b byte=%h expected 0 55", dav_, byte_out);
        else pass_cnt++;
        #2 reset_ = 1'b0;
        #1;
        chk_cnt++;
        if (dav_ !== 1'b1 || byte_out !== 8'h00)
            $display("FAIL rst_mid_async: got dav_=%b byte=%h expected 1 00", dav_, byte_out);
        else pass_cnt++;
        @(negedge clock);
        reset_ = 1'b1;
        tsr_read(v);
        chk_cnt++;
        if (v !== 8'h30) $display("FAIL rst_mid_tsr: got %h expected 30", v); else pass_cnt++;
        repeat (6) @(negedge clock);
        chk_cnt++;
        if (dav_ !== 1'b1) $display("FAIL rst_mid_idle_dav: got %b expected 1", dav_); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_hold_write();
        test_overflow();
        test_push_on_pop();
        test_reset_mid_handshake();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
